// File: rtl/pipe_pkg.sv
// Shared definitions for the scrolling pipe field: state encodings, LFSR taps
// and default field geometry.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned DEFAULT_CNT_BITS = 10;
    localparam int unsigned DEFAULT_SLOTS    = 5;
    localparam int unsigned DEFAULT_SPACING  = 107;
    localparam int unsigned DEFAULT_PIPE_W   = 26;
    localparam int unsigned DEFAULT_SCREEN_H = 240;
    localparam int unsigned DEFAULT_LEN_MIN  = 10;
    localparam int unsigned DEFAULT_LEN_MAX  = 140;
    localparam int unsigned DEFAULT_GAP_MIN  = 50;
    localparam int unsigned DEFAULT_GAP_MAX  = 70;
    localparam int unsigned DEFAULT_LEN      = 60;
    localparam int unsigned DEFAULT_GAP      = 60;
    localparam int unsigned DEFAULT_BIRD_X   = 40;
    localparam int unsigned DEFAULT_BIRD_W   = 12;
    localparam int unsigned DEFAULT_SCORE_W  = 14;
    localparam logic [15:0] DEFAULT_SEED     = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with asynchronous active-high reset to SEED.
module lfsr16
    import pipe_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_value
);

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/pipe_field_gen.sv
// Scrolling obstacle field: slot geometry, random pipe generation on wrap,
// pass counting and bird/pipe collision detection, all on the scroll tick.
module pipe_field_gen
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_BITS_N = DEFAULT_CNT_BITS,
    parameter int unsigned SLOTS      = DEFAULT_SLOTS,
    parameter int unsigned SPACING    = DEFAULT_SPACING,
    parameter int unsigned PIPE_W     = DEFAULT_PIPE_W,
    parameter int unsigned SCREEN_H   = DEFAULT_SCREEN_H,
    parameter int unsigned LEN_MIN    = DEFAULT_LEN_MIN,
    parameter int unsigned LEN_MAX    = DEFAULT_LEN_MAX,
    parameter int unsigned GAP_MIN    = DEFAULT_GAP_MIN,
    parameter int unsigned GAP_MAX    = DEFAULT_GAP_MAX,
    parameter int unsigned DEF_LEN    = DEFAULT_LEN,
    parameter int unsigned DEF_GAP    = DEFAULT_GAP,
    parameter int unsigned BIRD_X     = DEFAULT_BIRD_X,
    parameter int unsigned BIRD_W     = DEFAULT_BIRD_W,
    parameter int unsigned SCORE_BITS = DEFAULT_SCORE_W,
    parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED
) (
    input  logic                          rst,
    input  logic                          clk_scroll,
    input  logic                          start,
    input  logic                          pause,
    input  logic [2:0]                    speed,
    input  logic [CNT_BITS_N-1:0]         bird_y,
    input  logic [CNT_BITS_N-1:0]         bird_h,
    output logic [CNT_BITS_N-1:0]         pos,
    output logic [SLOTS*CNT_BITS_N-1:0]   slot_len,
    output logic [SLOTS*CNT_BITS_N-1:0]   slot_gap,
    output logic [SCORE_BITS-1:0]         score,
    output logic                          pass_pulse,
    output logic                          hit,
    output logic [1:0]                    state
);

    localparam int unsigned GW      = CNT_BITS_N + 2;
    localparam int unsigned LEN_MOD = LEN_MAX - LEN_MIN + 1;
    localparam int unsigned GAP_MOD = GAP_MAX - GAP_MIN + 1;

    typedef logic [GW-1:0]         geo_t;
    typedef logic [CNT_BITS_N-1:0] cnt_t;

    logic [15:0] w_lfsr;
    logic        w_lfsr_unused;

    state_e                r_state, w_state_nxt;
    cnt_t                  r_pos, w_pos_nxt;
    cnt_t                  r_len [SLOTS];
    cnt_t                  r_gap [SLOTS];
    cnt_t                  w_len_nxt [SLOTS];
    cnt_t                  w_gap_nxt [SLOTS];
    logic [SLOTS-1:0]      r_passed, w_passed_nxt, w_passed_tmp;
    logic [SCORE_BITS-1:0] r_score, w_score_nxt;
    logic                  r_pulse, w_pulse_nxt;
    logic                  r_hit, w_hit_nxt;

    geo_t             w_x [SLOTS];
    geo_t             w_bird_bot;
    logic [SLOTS-1:0] w_pass_cand, w_pass_sel, w_overlap, w_vert;
    logic             w_pass_any, w_hit_now, w_wrap, w_step;
    cnt_t             w_speed, w_new_len, w_new_gap;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (clk_scroll),
        .i_rst   (rst),
        .o_value (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[15:12];

    assign w_speed    = cnt_t'(speed);
    assign w_step     = !pause && (speed != 3'd0);
    assign w_wrap     = r_pos < w_speed;
    assign w_bird_bot = geo_t'(bird_y) + geo_t'(bird_h);
    assign w_new_len  = cnt_t'(32'(LEN_MIN) + 32'(w_lfsr[7:0]) % 32'(LEN_MOD));
    assign w_new_gap  = cnt_t'(32'(GAP_MIN) + 32'(w_lfsr[11:8]) % 32'(GAP_MOD));

    // Per-slot geometry tests, all on the current (pre-step) position.
    always_comb begin
        w_pass_cand = '0;
        w_overlap   = '0;
        w_vert      = '0;
        for (int k = 0; k < SLOTS; k++) begin
            w_x[k] = geo_t'(r_pos) + geo_t'(k * SPACING);
            w_pass_cand[k] = !r_passed[k] && (w_x[k] + geo_t'(PIPE_W) < geo_t'(BIRD_X));
            w_overlap[k] = (w_x[k] < geo_t'(BIRD_X + BIRD_W)) &&
                           (w_x[k] + geo_t'(PIPE_W) > geo_t'(BIRD_X));
            w_vert[k] = (geo_t'(bird_y) < geo_t'(r_len[k])) ||
                        (w_bird_bot > geo_t'(r_len[k]) + geo_t'(r_gap[k]));
        end
    end

    // Isolate the lowest candidate so at most one pass is counted per tick.
    assign w_pass_sel = w_pass_cand & (~w_pass_cand + SLOTS'(1));
    assign w_pass_any = |w_pass_cand;
    assign w_hit_now  = (|(w_overlap & w_vert)) || (w_bird_bot >= geo_t'(SCREEN_H));

    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_len_nxt    = r_len;
        w_gap_nxt    = r_gap;
        w_passed_nxt = r_passed;
        w_passed_tmp = r_passed | w_pass_sel;
        w_score_nxt  = r_score;
        w_pulse_nxt  = 1'b0;
        w_hit_nxt    = r_hit;

        unique case (r_state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    w_state_nxt  = ST_RUN;
                    w_pos_nxt    = cnt_t'(SPACING - 1);
                    w_passed_nxt = '0;
                    w_score_nxt  = '0;
                    w_hit_nxt    = 1'b0;
                    for (int k = 0; k < SLOTS; k++) begin
                        w_len_nxt[k] = cnt_t'(DEF_LEN);
                        w_gap_nxt[k] = cnt_t'(DEF_GAP);
                    end
                end
            end
            ST_RUN: begin
                if (w_step) begin
                    if (w_pass_any) begin
                        w_score_nxt = r_score + SCORE_BITS'(1);
                        w_pulse_nxt = 1'b1;
                    end
                    if (w_hit_now) begin
                        w_hit_nxt   = 1'b1;
                        w_state_nxt = ST_OVER;
                    end
                    if (w_wrap) begin
                        w_pos_nxt = cnt_t'(geo_t'(r_pos) + geo_t'(SPACING) - geo_t'(speed));
                        for (int k = 0; k < SLOTS - 1; k++) begin
                            w_len_nxt[k] = r_len[k+1];
                            w_gap_nxt[k] = r_gap[k+1];
                        end
                        w_len_nxt[SLOTS-1] = w_new_len;
                        w_gap_nxt[SLOTS-1] = w_new_gap;
                        w_passed_nxt       = {1'b0, w_passed_tmp[SLOTS-1:1]};
                    end else begin
                        w_pos_nxt    = r_pos - w_speed;
                        w_passed_nxt = w_passed_tmp;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_scroll or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pos    <= cnt_t'(SPACING - 1);
            r_passed <= '0;
            r_score  <= '0;
            r_pulse  <= 1'b0;
            r_hit    <= 1'b0;
            for (int k = 0; k < SLOTS; k++) begin
                r_len[k] <= cnt_t'(DEF_LEN);
                r_gap[k] <= cnt_t'(DEF_GAP);
            end
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_passed <= w_passed_nxt;
            r_score  <= w_score_nxt;
            r_pulse  <= w_pulse_nxt;
            r_hit    <= w_hit_nxt;
            r_len    <= w_len_nxt;
            r_gap    <= w_gap_nxt;
        end
    end

    always_comb begin
        slot_len = '0;
        slot_gap = '0;
        for (int k = 0; k < SLOTS; k++) begin
            slot_len[k*CNT_BITS_N +: CNT_BITS_N] = r_len[k];
            slot_gap[k*CNT_BITS_N +: CNT_BITS_N] = r_gap[k];
        end
    end

    assign pos        = r_pos;
    assign score      = r_score;
    assign pass_pulse = r_pulse;
    assign hit        = r_hit;
    assign state      = r_state;

endmodule

// File: doc/pipe_field_gen.md
Name: pipe_field_gen

Overview:
- Parametrised scrolling obstacle-field engine for the side-scroller game, clocked by the scroll tick.
- Maintains SLOTS pipe slots, each with an LFSR-generated length and gap, scrolls them at a variable speed, counts passed pipes and detects bird/pipe collision.
- Exports slot geometry to the pixel-clock renderer, and score and hit to game control.

Parameters:
- CNT_BITS_N, 10, width of position/length/gap fields (half-resolution pixels).
- SLOTS, 5, number of tracked pipe slots (2..8).
- SPACING, 107, horizontal pitch between consecutive pipe left edges.
- PIPE_W, 26, pipe width.
- SCREEN_H, 240, playfield height.
- LEN_MIN, 10 / LEN_MAX, 140, top-pipe length range; LEN_MAX+GAP_MAX <= SCREEN_H required.
- GAP_MIN, 50 / GAP_MAX, 70, opening height range.
- DEF_LEN, 60 / DEF_GAP, 60, slot contents loaded at reset/start.
- BIRD_X, 40 / BIRD_W, 12, fixed bird column and width.
- SCORE_BITS, 14, score counter width.
- LFSR_SEED, 16'hACE1, non-zero LFSR seed.

Ports:
- rst, input, 1, reset, asynchronous, active-high.
- clk_scroll, input, 1, scroll tick clock.
- start, input, 1, begin/restart game (level, sampled each tick).
- pause, input, 1, hold scrolling while high in RUN.
- speed, input, 3, pixels advanced per tick; 0 = frozen.
- bird_y, input, CNT_BITS_N, bird top edge.
- bird_h, input, CNT_BITS_N, bird height.
- pos, output, CNT_BITS_N, left edge x of slot 0; slot k at pos+k*SPACING.
- slot_len, output, SLOTS*CNT_BITS_N, packed top lengths, slot 0 in LSBs.
- slot_gap, output, SLOTS*CNT_BITS_N, packed gap heights.
- score, output, SCORE_BITS, pipes passed this game.
- pass_pulse, output, 1, one-tick pulse per pipe passed.
- hit, output, 1, collision occurred (sticky until start).
- state, output, 2, 0 IDLE, 1 RUN, 2 OVER.

Behaviour:
- Reset (async):
  - state=IDLE, pos=SPACING-1, every slot len=DEF_LEN and gap=DEF_GAP, passed flags cleared.
  - score=0, pass_pulse=0, hit=0, lfsr=LFSR_SEED.
- LFSR: 16-bit Galois, taps 16,14,13,11; advances every tick outside reset, in all states.
- IDLE or OVER with start=1: reload the slot defaults, pos=SPACING-1, score=0, hit=0 and passed flags cleared, then go to RUN next tick. The LFSR is not reseeded.
- RUN with pause=1 or speed=0: every register holds except the LFSR.
- RUN scroll step:
  - If pos >= speed: pos -= speed.
  - Otherwise wrap: pos <= pos+SPACING-speed, and slot i <= slot i+1 (length, gap, passed).
  - Slot SLOTS-1 gets a new pipe: len = LEN_MIN + lfsr[7:0] mod (LEN_MAX-LEN_MIN+1); gap = GAP_MIN + lfsr[11:8] mod (GAP_MAX-GAP_MIN+1); passed=0.
  - Both moduli are computed from constant parameters.
- Pass detection uses the current-tick pos.
  - The lowest slot k with passed=0 and pos+k*SPACING+PIPE_W < BIRD_X gets passed=1.
  - That tick also sets score+=1 (wraps at 2^SCORE_BITS) and asserts pass_pulse for exactly one tick.
  - At most one pass is counted per tick.
- Collision uses the current-tick pos.
  - Horizontal overlap: slot x < BIRD_X+BIRD_W and x+PIPE_W > BIRD_X.
  - Vertical hit: bird_y < len, or bird_y+bird_h > len+gap.
  - Out of field: bird_y+bird_h >= SCREEN_H is also a hit.
  - Any hit sets hit=1 and state=OVER on the same edge; the field then freezes.
- If a hit and a pass occur on the same tick, both are recorded: score increments and the state goes to OVER.
- If a wrap and a pass occur together, the pass is evaluated on the pre-shift slots and the passed flag shifts with its slot.
- Width rules: all geometry sums are evaluated in CNT_BITS_N+2 bits so they never overflow. Outputs are registered, so there is one tick of latency from an input to its effect.
- start is ignored in RUN.
- Reset mid-game restores the full reset state immediately.

Decomposition:
- Shared package pipe_pkg holds:
  - state encodings (ST_IDLE, ST_RUN, ST_OVER);
  - LFSR tap mask;
  - default geometry constants.
- One sub-module, lfsr16: registered Galois LFSR with async reset and seed parameter, reused by future randomised blocks.

Test Plan:
- Reset then start=1 with speed=1: state is RUN after 1 tick; pos counts 106,105,… down to 0, then wraps to 106 with slots shifted, and slot 4's len lies in [10,140] and gap in [50,70].
- speed=3 at pos=1: next pos=105; exactly one shift occurs.
- Bird at y=100, h=10, start pos=106, speed=1: slot 0 (len 60, gap 60) passes when pos+26<40, i.e. at pos=13. pass_pulse is high for one tick, score=1, and there is no hit.
- Bird at y=20 while slot 0 overlaps BIRD_X (pos=30): hit=1 and state=OVER on that tick; pos and score freeze on subsequent ticks; start then restores defaults and score=0.
- pause=1 for 10 ticks in RUN: pos and score unchanged; the LFSR advances, so the next generated slot differs from a run without the pause.
- rst asserted asynchronously mid-RUN between clock edges: outputs immediately take their reset values (pos=106, state=IDLE, hit=0).
